// File: rtl/alu_pkg.sv
// Shared ALU issue constants: ALUFun codes, MIPS opcodes/functs, decode bundles.
// Optional illegal-encoding reporting is enabled by ALU_ISSUE_ILLEGAL_EN.
package alu_pkg;

  localparam logic [1:0] CLS_ADD   = 2'b00;
  localparam logic [1:0] CLS_LOGIC = 2'b01;
  localparam logic [1:0] CLS_SHIFT = 2'b10;
  localparam logic [1:0] CLS_CMP   = 2'b11;

  localparam logic [5:0] FUN_ADD   = {CLS_ADD,   4'b0000};
  localparam logic [5:0] FUN_SUB   = {CLS_ADD,   4'b0001};
  localparam logic [5:0] FUN_AND   = {CLS_LOGIC, 4'b1000};
  localparam logic [5:0] FUN_OR    = {CLS_LOGIC, 4'b1110};
  localparam logic [5:0] FUN_XOR   = {CLS_LOGIC, 4'b0110};
  localparam logic [5:0] FUN_NOR   = {CLS_LOGIC, 4'b0001};
  localparam logic [5:0] FUN_PASSA = {CLS_LOGIC, 4'b1010};
  localparam logic [5:0] FUN_SLL   = {CLS_SHIFT, 4'b0000};
  localparam logic [5:0] FUN_SRL   = {CLS_SHIFT, 4'b0001};
  localparam logic [5:0] FUN_SRA   = {CLS_SHIFT, 4'b0011};
  localparam logic [5:0] FUN_EQ    = {CLS_CMP,   4'b0011};
  localparam logic [5:0] FUN_NE    = {CLS_CMP,   4'b0001};
  localparam logic [5:0] FUN_LT    = {CLS_CMP,   4'b0101};
  localparam logic [5:0] FUN_LEZ   = {CLS_CMP,   4'b1101};
  localparam logic [5:0] FUN_LTZ   = {CLS_CMP,   4'b1011};
  localparam logic [5:0] FUN_GTZ   = {CLS_CMP,   4'b1111};

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    EXT_SIGN,
    EXT_ZERO,
    EXT_SHAMT,
    EXT_LUI
  } ext_sel_e;

  typedef enum logic [2:0] {
    A_ZERO,
    A_RS,
    A_EXT,
    A_PC4,
    A_SIXTEEN
  } a_sel_e;

  typedef enum logic [1:0] {
    B_ZERO,
    B_RT,
    B_EXT
  } b_sel_e;

  typedef struct packed {
    logic [5:0] fun;
    logic       sign;
    a_sel_e     a_sel;
    b_sel_e     b_sel;
    ext_sel_e   ext;
    logic [4:0] wr_addr;
    logic       reg_write;
    logic       mem_rd;
    logic       mem_wr;
    logic       illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
    logic [4:0]  wr_addr;
    logic        reg_write;
    logic        mem_rd;
    logic        mem_wr;
  } id_ex_t;

  localparam dec_t DEC_BUBBLE = '{
    fun:       FUN_ADD,
    sign:      1'b1,
    a_sel:     A_ZERO,
    b_sel:     B_ZERO,
    ext:       EXT_SIGN,
    wr_addr:   5'd0,
    reg_write: 1'b0,
    mem_rd:    1'b0,
    mem_wr:    1'b0,
    illegal:   1'b0
  };

  // shamt lives in imm[10:6] of an R-type word
  function automatic logic [31:0] ext_imm(
    input ext_sel_e    sel,
    input logic [15:0] imm
  );
    logic [31:0] r;
    case (sel)
      EXT_SIGN:  r = {{16{imm[15]}}, imm};
      EXT_SHAMT: r = {27'd0, imm[10:6]};
      default:   r = {16'd0, imm};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_fun_decode.sv
// Combinational MIPS decode: instr -> ALUFun, Sign, operand selects,
// destination, enables and an illegal-encoding flag.
module alu_fun_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_rs;

  assign op        = instr[31:26];
  assign fn        = instr[5:0];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign unused_rs = ^instr[25:21];

  always_comb begin
    dec = DEC_BUBBLE;
    case (op)
      OP_RTYPE: begin
        dec.a_sel     = A_RS;
        dec.b_sel     = B_RT;
        dec.wr_addr   = rd;
        dec.reg_write = 1'b1;
        case (fn)
          F_ADD:  dec.fun = FUN_ADD;
          F_ADDU: begin
            dec.fun  = FUN_ADD;
            dec.sign = 1'b0;
          end
          F_SUB:  dec.fun = FUN_SUB;
          F_SUBU: begin
            dec.fun  = FUN_SUB;
            dec.sign = 1'b0;
          end
          F_AND:  dec.fun = FUN_AND;
          F_OR:   dec.fun = FUN_OR;
          F_XOR:  dec.fun = FUN_XOR;
          F_NOR:  dec.fun = FUN_NOR;
          F_SLT:  dec.fun = FUN_LT;
          F_SLTU: begin
            dec.fun  = FUN_LT;
            dec.sign = 1'b0;
          end
          F_SLL, F_SRL, F_SRA: begin
            dec.a_sel = A_EXT;
            dec.ext   = EXT_SHAMT;
            dec.fun   = (fn == F_SLL) ? FUN_SLL :
                        (fn == F_SRL) ? FUN_SRL : FUN_SRA;
          end
          F_SLLV: dec.fun = FUN_SLL;
          F_SRLV: dec.fun = FUN_SRL;
          F_SRAV: dec.fun = FUN_SRA;
          F_JR: begin
            dec.fun       = FUN_PASSA;
            dec.wr_addr   = 5'd0;
            dec.reg_write = 1'b0;
          end
          F_JALR: begin
            dec.fun   = FUN_PASSA;
            dec.a_sel = A_PC4;
            dec.b_sel = B_ZERO;
          end
          default: begin
            dec         = DEC_BUBBLE;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_J: begin
        dec.fun   = FUN_PASSA;
        dec.a_sel = A_PC4;
      end
      OP_JAL: begin
        dec.fun       = FUN_PASSA;
        dec.a_sel     = A_PC4;
        dec.wr_addr   = 5'd31;
        dec.reg_write = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        dec.a_sel     = A_RS;
        dec.b_sel     = B_EXT;
        dec.ext       = EXT_SIGN;
        dec.wr_addr   = rt;
        dec.reg_write = 1'b1;
        dec.fun       = (op == OP_ADDI || op == OP_ADDIU) ?
                        FUN_ADD : FUN_LT;
        dec.sign      = (op == OP_ADDI || op == OP_SLTI);
      end
      OP_ANDI, OP_ORI: begin
        dec.a_sel     = A_RS;
        dec.b_sel     = B_EXT;
        dec.ext       = EXT_ZERO;
        dec.wr_addr   = rt;
        dec.reg_write = 1'b1;
        dec.fun       = (op == OP_ANDI) ? FUN_AND : FUN_OR;
      end
      OP_LUI: begin
        dec.a_sel     = A_SIXTEEN;
        dec.b_sel     = B_EXT;
        dec.ext       = EXT_LUI;
        dec.fun       = FUN_SLL;
        dec.wr_addr   = rt;
        dec.reg_write = 1'b1;
      end
      OP_LW: begin
        dec.a_sel     = A_RS;
        dec.b_sel     = B_EXT;
        dec.wr_addr   = rt;
        dec.reg_write = 1'b1;
        dec.mem_rd    = 1'b1;
      end
      OP_SW: begin
        dec.a_sel  = A_RS;
        dec.b_sel  = B_EXT;
        dec.mem_wr = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.a_sel = A_RS;
        dec.b_sel = B_RT;
        dec.fun   = (op == OP_BEQ) ? FUN_EQ : FUN_NE;
      end
      OP_BLEZ, OP_BGTZ: begin
        dec.a_sel = A_RS;
        dec.fun   = (op == OP_BLEZ) ? FUN_LEZ : FUN_GTZ;
      end
      OP_REGIMM: begin
        if (rt == 5'd0) begin
          dec.a_sel = A_RS;
          dec.fun   = FUN_LTZ;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.wr_addr == 5'd0) dec.reg_write = 1'b0;
  end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: decode, operand muxes and a single valid/ready slot.
// Define ALU_ISSUE_ILLEGAL_EN to expose the registered illegal flag.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] pc_plus4,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] DataA,
  output logic [31:0] DataB,
  output logic [5:0]  ALUFun,
  output logic        Sign,
  output logic [4:0]  wr_addr,
  output logic        reg_write,
  output logic        mem_rd,
  output logic        mem_wr
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic        illegal
`endif
);

  dec_t        dec;
  id_ex_t      ex_d;
  id_ex_t      ex_q;
  logic        valid_d;
  logic        valid_q;
  logic        load;
  logic [31:0] ext_val;
  logic [31:0] a_mux;
  logic [31:0] b_mux;

  alu_fun_decode u_dec (
    .instr (instr),
    .dec   (dec)
  );

  always_comb begin
    ext_val = ext_imm(dec.ext, instr[15:0]);
    case (dec.a_sel)
      A_RS:      a_mux = rs_data;
      A_EXT:     a_mux = ext_val;
      A_PC4:     a_mux = pc_plus4;
      A_SIXTEEN: a_mux = 32'd16;
      default:   a_mux = 32'd0;
    endcase
    case (dec.b_sel)
      B_RT:    b_mux = rt_data;
      B_EXT:   b_mux = ext_val;
      default: b_mux = 32'd0;
    endcase
  end

  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  // flush keeps the stale payload but kills its side effects
  always_comb begin
    valid_d = valid_q;
    ex_d    = ex_q;
    if (flush) begin
      valid_d        = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_rd    = 1'b0;
      ex_d.mem_wr    = 1'b0;
    end else if (load) begin
      valid_d        = 1'b1;
      ex_d.a         = a_mux;
      ex_d.b         = b_mux;
      ex_d.fun       = dec.fun;
      ex_d.sign      = dec.sign;
      ex_d.wr_addr   = dec.wr_addr;
      ex_d.reg_write = dec.reg_write;
      ex_d.mem_rd    = dec.mem_rd;
      ex_d.mem_wr    = dec.mem_wr;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ex_q    <= ex_d;
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic ill_d;
  logic ill_q;

  always_comb begin
    ill_d = ill_q;
    if (!flush && load) ill_d = dec.illegal;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ill_q <= 1'b0;
    else        ill_q <= ill_d;
  end

  assign illegal = ill_q;
`else
  logic unused_ill;
  assign unused_ill = dec.illegal;
`endif

  assign out_valid = valid_q;
  assign DataA     = ex_q.a;
  assign DataB     = ex_q.b;
  assign ALUFun    = ex_q.fun;
  assign Sign      = ex_q.sign;
  assign wr_addr   = ex_q.wr_addr;
  assign reg_write = ex_q.reg_write;
  assign mem_rd    = ex_q.mem_rd;
  assign mem_wr    = ex_q.mem_wr;

endmodule
